// File: rtl/instr_batch_arbiter.sv
// Round-robin arbiter between two instruction producers feeding the batch writer.
// Screens batch sizes, registers the granted batch and tracks RAM occupancy.
module instr_batch_arbiter #(
  parameter int DEPTH = 1024,
  parameter int CNT_W = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [191:0]       req0_instructions,
  input  logic [3:0]         req0_quantity,
  input  logic [191:0]       req1_instructions,
  input  logic [3:0]         req1_quantity,
  input  logic               release_all,
  output logic               wr_enable,
  output logic [191:0]       wr_instructions,
  output logic [3:0]         wr_quantity,
  output logic [CNT_W-1:0]   words_used,
  output logic               full,
  output logic               err_pulse,
  output logic               err_src
);

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

  state_t             state_r;
  logic               rr_r;
  logic               wr_enable_r;
  logic [191:0]       wr_instructions_r;
  logic [3:0]         wr_quantity_r;
  logic [CNT_W-1:0]   words_used_r;
  logic               err_pulse_r;
  logic               err_src_r;

  logic               cand_s;
  logic               cand_valid_s;
  logic [3:0]         cand_q_s;
  logic [191:0]       cand_instr_s;
  logic               legal_s;
  logic [CNT_W:0]     sum_s;
  logic               fits_s;
  logic               grant_s;

  function automatic logic qty_legal(input logic [3:0] q);
    return (q >= 4'd2) && (q <= 4'd6);
  endfunction

  // Candidate selection, legality and fit check; ready is Mealy on these.
  always_comb begin
    cand_s       = 1'b0;
    cand_valid_s = 1'b0;
    cand_q_s     = 4'd0;
    cand_instr_s = '0;
    grant_s      = 1'b0;
    req_ready    = 2'b00;
    if (req_valid[rr_r]) begin
      cand_s = rr_r;
    end else begin
      cand_s = ~rr_r;
    end
    cand_valid_s = req_valid[cand_s];
    if (cand_s) begin
      cand_q_s     = req1_quantity;
      cand_instr_s = req1_instructions;
    end else begin
      cand_q_s     = req0_quantity;
      cand_instr_s = req0_instructions;
    end
    legal_s = qty_legal(cand_q_s);
    sum_s   = {1'b0, words_used_r} + {{(CNT_W-3){1'b0}}, cand_q_s};
    fits_s  = (sum_s <= DEPTH_C);
    // Illegal batches are always drained; legal ones wait until they fit.
    if ((state_r == IDLE) && cand_valid_s && (!legal_s || fits_s)) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    if (grant_s) begin
      req_ready = cand_s ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
  end

  // Arbitration FSM with registered write, error and occupancy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= IDLE;
      rr_r              <= 1'b0;
      wr_enable_r       <= 1'b0;
      wr_instructions_r <= '0;
      wr_quantity_r     <= 4'd0;
      words_used_r      <= '0;
      err_pulse_r       <= 1'b0;
      err_src_r         <= 1'b0;
    end else begin
      err_pulse_r <= 1'b0;
      case (state_r)
        IDLE: begin
          wr_enable_r <= 1'b0;
          if (grant_s) begin
            rr_r <= ~cand_s;
            if (legal_s) begin
              wr_instructions_r <= cand_instr_s;
              wr_quantity_r     <= cand_q_s;
              wr_enable_r       <= 1'b1;
              state_r           <= ISSUE;
            end else begin
              err_pulse_r <= 1'b1;
              err_src_r   <= cand_s;
            end
          end
        end
        ISSUE: begin
          wr_enable_r <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          wr_enable_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
      // A release during ISSUE also covers the batch being written.
      if (release_all) begin
        words_used_r <= '0;
      end else if (state_r == ISSUE) begin
        words_used_r <= words_used_r + {{(CNT_W-4){1'b0}}, wr_quantity_r};
      end
    end
  end

  assign wr_enable       = wr_enable_r;
  assign wr_instructions = wr_instructions_r;
  assign wr_quantity     = wr_quantity_r;
  assign words_used      = words_used_r;
  assign full            = ((DEPTH_C - {1'b0, words_used_r}) < (CNT_W+1)'(2));
  assign err_pulse       = err_pulse_r;
  assign err_src         = err_src_r;

endmodule

// File: tb/tb_instr_batch_arbiter.sv
// Directed bench for instr_batch_arbiter with hand-computed expectations.
module tb_instr_batch_arbiter;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [191:0]  req0_instructions = '0;
  logic [3:0]    req0_quantity = 4'd0;
  logic [191:0]  req1_instructions = '0;
  logic [3:0]    req1_quantity = 4'd0;
  logic          release_all = 1'b0;
  logic          wr_enable;
  logic [191:0]  wr_instructions;
  logic [3:0]    wr_quantity;
  logic [10:0]   words_used;
  logic          full;
  logic          err_pulse;
  logic          err_src;

  int vectors = 0;
  int miscompares = 0;

  logic [191:0] pat_a = 192'h0123_4567_89AB_CDEF_1111_2222_3333_4444_5555_6666_7777_8888;
  logic [191:0] pat_b = 192'hFEDC_BA98_7654_3210_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_9999;

  instr_batch_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_instructions(req0_instructions), .req0_quantity(req0_quantity),
    .req1_instructions(req1_instructions), .req1_quantity(req1_quantity),
    .release_all(release_all), .wr_enable(wr_enable), .wr_instructions(wr_instructions),
    .wr_quantity(wr_quantity), .words_used(words_used), .full(full),
    .err_pulse(err_pulse), .err_src(err_src)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = 2'b00;
    release_all = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic fill_1020;
    req_valid = 2'b11;
    req0_quantity = 4'd6;
    req1_quantity = 4'd6;
    repeat (340) tick();
    req_valid = 2'b00;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    vectors++; if (wr_enable !== 1'b0) begin miscompares++; $display("FAIL reset_wr_enable got=%b exp=0", wr_enable); end
    vectors++; if (wr_quantity !== 4'd0) begin miscompares++; $display("FAIL reset_wr_quantity got=%0d exp=0", wr_quantity); end
    vectors++; if (wr_instructions !== 192'd0) begin miscompares++; $display("FAIL reset_wr_instructions got=%h exp=0", wr_instructions); end
    vectors++; if (words_used !== 11'd0) begin miscompares++; $display("FAIL reset_words_used got=%0d exp=0", words_used); end
    vectors++; if ({err_pulse, err_src} !== 2'b00) begin miscompares++; $display("FAIL reset_err got=%b exp=00", {err_pulse, err_src}); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got=%b exp=0", full); end
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
  endtask

  task automatic test_single;
    do_reset();
    req0_instructions = pat_a;
    req0_quantity = 4'd3;
    req_valid = 2'b01;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    tick();
    vectors++; if (wr_enable !== 1'b1) begin miscompares++; $display("FAIL single_wr_enable got=%b exp=1", wr_enable); end
    vectors++; if (wr_quantity !== 4'd3) begin miscompares++; $display("FAIL single_wr_quantity got=%0d exp=3", wr_quantity); end
    vectors++; if (wr_instructions !== pat_a) begin miscompares++; $display("FAIL single_wr_instr got=%h exp=%h", wr_instructions, pat_a); end
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL single_ready_in_issue got=%b exp=00", req_ready); end
    req_valid = 2'b00;
    tick();
    vectors++; if (wr_enable !== 1'b0) begin miscompares++; $display("FAIL single_wr_enable_drop got=%b exp=0", wr_enable); end
    vectors++; if (words_used !== 11'd3) begin miscompares++; $display("FAIL single_words_used got=%0d exp=3", words_used); end
    vectors++; if (wr_quantity !== 4'd3) begin miscompares++; $display("FAIL single_wr_quantity_hold got=%0d exp=3", wr_quantity); end
  endtask

  task automatic test_back_to_back;
    logic [1:0]   exp_ready;
    logic [191:0] exp_instr;
    do_reset();
    req0_instructions = pat_a;
    req1_instructions = pat_b;
    req0_quantity = 4'd2;
    req1_quantity = 4'd2;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_ready = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_instr = (i % 2 == 0) ? pat_a : pat_b;
      #1;
      vectors++; if (req_ready !== exp_ready) begin miscompares++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, req_ready, exp_ready); end
      tick();
      vectors++; if ((wr_enable !== 1'b1) || (wr_instructions !== exp_instr)) begin
        miscompares++; $display("FAIL b2b_write[%0d] got en=%b instr=%h exp en=1 instr=%h", i, wr_enable, wr_instructions, exp_instr);
      end
      tick();
      vectors++; if (wr_enable !== 1'b0) begin miscompares++; $display("FAIL b2b_gap[%0d] got=%b exp=0", i, wr_enable); end
    end
    req_valid = 2'b00;
    vectors++; if (words_used !== 11'd8) begin miscompares++; $display("FAIL b2b_words_used got=%0d exp=8", words_used); end
  endtask

  task automatic test_illegal;
    do_reset();
    req1_quantity = 4'd7;
    req_valid = 2'b10;
    #1;
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL illegal7_ready got=%b exp=10", req_ready); end
    tick();
    vectors++; if ({err_pulse, err_src, wr_enable} !== 3'b110) begin miscompares++; $display("FAIL illegal7_err got=%b exp=110", {err_pulse, err_src, wr_enable}); end
    req1_quantity = 4'd1;
    #1;
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL illegal1_ready got=%b exp=10", req_ready); end
    tick();
    vectors++; if ({err_pulse, err_src, wr_enable} !== 3'b110) begin miscompares++; $display("FAIL illegal1_err got=%b exp=110", {err_pulse, err_src, wr_enable}); end
    req_valid = 2'b00;
    tick();
    vectors++; if ({err_pulse, err_src, wr_enable} !== 3'b010) begin miscompares++; $display("FAIL illegal_after got=%b exp=010", {err_pulse, err_src, wr_enable}); end
    vectors++; if (words_used !== 11'd0) begin miscompares++; $display("FAIL illegal_words_used got=%0d exp=0", words_used); end
  endtask

  task automatic test_head_of_line;
    do_reset();
    fill_1020();
    vectors++; if (words_used !== 11'd1020) begin miscompares++; $display("FAIL hol_fill got=%0d exp=1020", words_used); end
    req0_quantity = 4'd5;
    req1_quantity = 4'd2;
    req_valid = 2'b11;
    #1;
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL hol_ready got=%b exp=00", req_ready); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL hol_full got=%b exp=0", full); end
    tick();
    vectors++; if ({req_ready, wr_enable} !== 3'b000) begin miscompares++; $display("FAIL hol_hold got=%b exp=000", {req_ready, wr_enable}); end
    release_all = 1'b1;
    tick();
    release_all = 1'b0;
    #1;
    vectors++; if (words_used !== 11'd0) begin miscompares++; $display("FAIL hol_release got=%0d exp=0", words_used); end
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL hol_grant got=%b exp=01", req_ready); end
    tick();
    req_valid = 2'b00;
    vectors++; if ((wr_enable !== 1'b1) || (wr_quantity !== 4'd5)) begin miscompares++; $display("FAIL hol_write got en=%b q=%0d exp en=1 q=5", wr_enable, wr_quantity); end
    tick();
    vectors++; if (words_used !== 11'd5) begin miscompares++; $display("FAIL hol_words_used got=%0d exp=5", words_used); end
  endtask

  task automatic test_full_release;
    do_reset();
    fill_1020();
    req0_quantity = 4'd3;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    vectors++; if ((words_used !== 11'd1023) || (full !== 1'b1)) begin miscompares++; $display("FAIL full_set got used=%0d full=%b exp used=1023 full=1", words_used, full); end
    req0_quantity = 4'd2;
    req_valid = 2'b01;
    #1;
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL full_no_fit got=%b exp=00", req_ready); end
    req_valid = 2'b00;
    release_all = 1'b1;
    tick();
    release_all = 1'b0;
    req1_quantity = 4'd4;
    req1_instructions = pat_b;
    req_valid = 2'b10;
    #1;
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL full_grant1 got=%b exp=10", req_ready); end
    tick();
    req_valid = 2'b00;
    release_all = 1'b1;
    vectors++; if ((wr_enable !== 1'b1) || (wr_quantity !== 4'd4)) begin miscompares++; $display("FAIL full_issue got en=%b q=%0d exp en=1 q=4", wr_enable, wr_quantity); end
    tick();
    release_all = 1'b0;
    vectors++; if ((words_used !== 11'd0) || (full !== 1'b0)) begin miscompares++; $display("FAIL full_release_in_issue got used=%0d full=%b exp used=0 full=0", words_used, full); end
  endtask

  task automatic test_reset_mid_issue;
    do_reset();
    req0_quantity = 4'd2;
    req1_quantity = 4'd2;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    vectors++; if (wr_enable !== 1'b1) begin miscompares++; $display("FAIL rst_mid_pre got=%b exp=1", wr_enable); end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++; if ({wr_enable, wr_quantity} !== 5'b0_0000) begin miscompares++; $display("FAIL rst_mid_async got=%b exp=00000", {wr_enable, wr_quantity}); end
    rst_n = 1'b1;
    tick();
    vectors++; if ((words_used !== 11'd0) || (wr_enable !== 1'b0)) begin miscompares++; $display("FAIL rst_mid_lost got used=%0d en=%b exp used=0 en=0", words_used, wr_enable); end
    req_valid = 2'b11;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rst_mid_rr got=%b exp=01", req_ready); end
    req_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal();
    test_head_of_line();
    test_full_release();
    test_reset_mid_issue();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_batch_arbiter.md
# instr_batch_arbiter

Shares the single batch-write port of the instruction RAM writer between two instruction producers. The writer stores 2–6 32-bit instructions per pulse into a 1024-word RAM at a free-running cursor. This block sits directly upstream of the writer and does four things:
- arbitrates round-robin between the two producers;
- rejects illegal batch sizes;
- registers the selected batch and drives exactly one write pulse per accepted batch;
- tracks RAM occupancy so the cursor never overwrites unconsumed words.

## Interface
Parameters:
- DEPTH, 1024: RAM depth in 32-bit words; must match the writer.
- CNT_W, 11: width of the occupancy counter; must hold the value DEPTH.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  2  per-requester batch valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept strobe; a transfer occurs when req_valid[i] & req_ready[i].
- req0_instructions  input  192  requester 0 batch; word k is in bits [32k+31:32k].
- req0_quantity  input  4  requester 0 word count.
- req1_instructions  input  192  requester 1 batch.
- req1_quantity  input  4  requester 1 word count.
- release_all  input  1  the consumer has read every stored word; clears occupancy.
- wr_enable  output  1  write pulse to the writer.
- wr_instructions  output  192  registered batch to the writer.
- wr_quantity  output  4  registered word count to the writer.
- words_used  output  CNT_W  current RAM occupancy.
- full  output  1  high when DEPTH − words_used < 2 (no legal batch can fit).
- err_pulse  output  1  one-cycle flag: an illegal quantity was consumed.
- err_src  output  1  requester index of the last error; holds until the next error.

## Operation
- FSM has two states, IDLE and ISSUE. Reset puts it in IDLE.
- Reset values: wr_enable=0, wr_instructions=0, wr_quantity=0, words_used=0, err_pulse=0, err_src=0, round-robin pointer rr=0.
- req_ready is 0 whenever the FSM is in ISSUE.

Candidate selection in IDLE:
- If req_valid[rr] is high, the candidate is rr; otherwise it is the other requester.
- The candidate's own valid bit must be high; if no valid bit is high, nothing happens.

Legal quantity = 2..6 inclusive. Quantity 0, 1 and 7–15 are illegal.

Candidate with illegal quantity:
- req_ready[cand]=1 for that cycle; the batch is consumed and discarded.
- Next cycle: err_pulse=1, err_src=cand.
- No write is issued; rr ← ~cand; the FSM stays in IDLE.

Candidate with legal quantity that fits (words_used + q ≤ DEPTH):
- req_ready[cand]=1.
- wr_instructions and wr_quantity are registered; rr ← ~cand; FSM → ISSUE.

Candidate with legal quantity that does not fit:
- No ready is given and rr is unchanged (head-of-line hold).
- The other requester is never considered in its place, even if its batch would fit.

ISSUE state:
- wr_enable=1 for exactly this cycle.
- words_used ← words_used + wr_quantity; FSM → IDLE.
- wr_instructions and wr_quantity hold their values until the next accept.

release_all:
- In IDLE, words_used ← 0.
- In ISSUE, the write still issues and words_used ← 0, so the in-flight batch counts as released.
- release_all has priority over the increment.

Arithmetic:
- words_used + q is computed at CNT_W+1 bits; no wrap is possible.
- words_used never exceeds DEPTH.

## Timing
- req_ready is Mealy, combinational from req_valid, quantity, rr, words_used and state.
- A requester holds valid and data stable until it is accepted.
- Accept in cycle N → wr_enable in cycle N+1. Maximum throughput is one batch every 2 cycles.
- words_used and full reflect the write in cycle N+2.
- err_pulse occurs in cycle N+1 of an illegal accept.
- Reset asserted mid-ISSUE: wr_enable drops immediately (asynchronous reset) and the batch is lost; words_used=0.

## Test plan
- Requester 0 only, q=3, words_used=0 → ready0 in cycle 0; wr_enable in cycle 1 with wr_quantity=3; words_used=3 in cycle 2.
- Both requesters valid continuously, q=2 each, from reset → grants alternate 0,1,0,1; wr_enable in every other cycle; words_used=8 after 4 writes.
- Requester 1 with q=7, then q=1 → each is consumed with ready1; err_pulse=1 with err_src=1 both times; no wr_enable; words_used unchanged.
- Fill to words_used=1020; requester 0 q=5 and requester 1 q=2 with rr=0 → no grants (head-of-line); full=0. Then release_all → words_used=0; the next cycle grants requester 0.
- words_used=1023 → full=1. release_all asserted in an ISSUE cycle with q=4 → wr_enable=1 and words_used=0 the next cycle.
- rst_n pulled low in an ISSUE cycle → wr_enable=0 and rr=0 immediately; after release, the first grant goes to requester 0.
